// File: rtl/lin_sys_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lin_sys_classifier                                            |
// | Purpose  : ranks A and [A|d] of a streamed NxN system by fraction-free   |
// |            elimination and classifies it as unique/infinite/inconsistent |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lin_sys_classifier #(
   parameter int N  = 3,
   parameter int W  = 4,
   parameter int IW = W << (N-1),
   parameter int RW = $clog2(N+2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [(N+1)*W-1:0]   row_data,
   output logic                 busy,
   output logic                 done,
   output logic [RW-1:0]        rank_a,
   output logic [RW-1:0]        rank_ab,
   output logic [1:0]           sol_class
);

   localparam int               c_riw      = (N > 1) ? $clog2(N) : 1;
   localparam int               c_ciw      = $clog2(N+1);
   localparam logic [c_riw-1:0] c_last_row = c_riw'(N-1);
   localparam logic [RW-1:0]    c_n        = RW'(N);
   localparam logic [RW-1:0]    c_n_plus1  = RW'(N+1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SEARCH   = 3'd2,
      S_SWAP     = 3'd3,
      S_ELIM     = 3'd4,
      S_CLASSIFY = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [c_riw-1:0]     r_row_cnt;
   logic [c_riw-1:0]     r_s;
   logic [c_riw-1:0]     r_j;
   logic [RW-1:0]        r_r;
   logic [RW-1:0]        r_col;
   logic [RW-1:0]        r_pivots;
   logic [RW-1:0]        r_pivots_a;
   logic signed [IW-1:0] r_mat [N][N+1];

   logic                 w_accept;
   logic                 w_term;
   logic                 w_hit;
   logic [c_riw-1:0]     w_r_idx;
   logic [c_ciw-1:0]     w_c_idx;
   logic signed [IW-1:0] w_piv;
   logic signed [IW-1:0] w_fac;
   logic signed [IW-1:0] w_new [N+1];

   assign w_accept = in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));
   assign w_term   = (r_col == c_n_plus1) || (r_r == c_n);
   assign w_r_idx  = r_r[c_riw-1:0];
   assign w_c_idx  = r_col[c_ciw-1:0];
   assign w_hit    = (r_mat[r_s][w_c_idx] != '0);
   assign w_piv    = r_mat[w_r_idx][w_c_idx];
   assign w_fac    = r_mat[r_j][w_c_idx];

   // Only the low IW bits of each product survive, and magnitudes never exceed IW.
   generate
      for (genvar k = 0; k <= N; k++) begin : g_elim
         assign w_new[k] = w_piv * r_mat[r_j][k] - w_fac * r_mat[w_r_idx][k];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = (r_row_cnt == c_last_row) ? S_SEARCH : S_LOAD;
         end
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (r_row_cnt == c_last_row)) w_state_nxt = S_SEARCH;
         end
         S_SEARCH: begin
            busy = 1'b1;
            if (w_term)     w_state_nxt = S_CLASSIFY;
            else if (w_hit) w_state_nxt = S_SWAP;
         end
         S_SWAP: begin
            busy        = 1'b1;
            w_state_nxt = (r_r == RW'(N-1)) ? S_SEARCH : S_ELIM;
         end
         S_ELIM: begin
            busy = 1'b1;
            if (r_j == c_last_row) w_state_nxt = S_SEARCH;
         end
         S_CLASSIFY: begin
            busy        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_cnt  <= '0;
         r_s        <= '0;
         r_j        <= '0;
         r_r        <= '0;
         r_col      <= '0;
         r_pivots   <= '0;
         r_pivots_a <= '0;
         rank_a     <= '0;
         rank_ab    <= '0;
         sol_class  <= 2'b00;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE, S_LOAD: begin
               if (w_accept) begin
                  if (r_row_cnt == c_last_row) begin
                     r_row_cnt  <= '0;
                     r_s        <= '0;
                     r_r        <= '0;
                     r_col      <= '0;
                     r_pivots   <= '0;
                     r_pivots_a <= '0;
                  end else begin
                     r_row_cnt <= r_row_cnt + c_riw'(1);
                  end
               end
            end
            S_SEARCH: begin
               if (w_term) begin
                  rank_a  <= r_pivots_a;
                  rank_ab <= r_pivots;
                  done    <= 1'b1;
                  if (r_pivots_a < r_pivots)  sol_class <= 2'b11;
                  else if (r_pivots_a == c_n) sol_class <= 2'b01;
                  else                        sol_class <= 2'b10;
               end else if (!w_hit) begin
                  if (r_s == c_last_row) begin
                     r_col <= r_col + RW'(1);
                     r_s   <= w_r_idx;
                  end else begin
                     r_s <= r_s + c_riw'(1);
                  end
               end
            end
            S_SWAP: begin
               r_pivots <= r_pivots + RW'(1);
               if (r_col < c_n) r_pivots_a <= r_pivots_a + RW'(1);
               if (r_r == RW'(N-1)) begin
                  r_r   <= r_r + RW'(1);
                  r_col <= r_col + RW'(1);
                  r_s   <= '0;
               end else begin
                  r_j <= w_r_idx + c_riw'(1);
               end
            end
            S_ELIM: begin
               if (r_j == c_last_row) begin
                  r_r   <= r_r + RW'(1);
                  r_col <= r_col + RW'(1);
                  r_s   <= w_r_idx + c_riw'(1);
               end else begin
                  r_j <= r_j + c_riw'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Matrix storage needs no reset: every slot is rewritten before elimination.
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE, S_LOAD: begin
            if (w_accept) begin
               for (int k = 0; k <= N; k++)
                  r_mat[r_row_cnt][k] <= IW'($signed(row_data[k*W +: W]));
            end
         end
         S_SWAP: begin
            for (int k = 0; k <= N; k++) begin
               r_mat[w_r_idx][k] <= r_mat[r_s][k];
               r_mat[r_s][k]     <= r_mat[w_r_idx][k];
            end
         end
         S_ELIM: begin
            if (w_fac != '0) begin
               for (int k = 0; k <= N; k++)
                  r_mat[r_j][k] <= w_new[k];
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_lin_sys_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lin_sys_classifier                                         |
// | Purpose  : scoreboard bench for lin_sys_classifier (N=3, W=4)            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lin_sys_classifier;

   localparam int N  = 3;
   localparam int W  = 4;
   localparam int RW = $clog2(N+2);

   typedef int mat_t [3][4];
   typedef struct {
      int ra;
      int rb;
      int cls;
   } exp_t;

   logic                 clk      = 1'b0;
   logic                 rst_n    = 1'b1;
   logic                 in_valid = 1'b0;
   logic [(N+1)*W-1:0]   row_data = '0;
   logic                 in_ready;
   logic                 busy;
   logic                 done;
   logic [RW-1:0]        rank_a;
   logic [RW-1:0]        rank_ab;
   logic [1:0]           sol_class;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   lin_sys_classifier #(.N(N), .W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .row_data  (row_data),
      .busy      (busy),
      .done      (done),
      .rank_a    (rank_a),
      .rank_ab   (rank_ab),
      .sol_class (sol_class)
   );

   task automatic check_value(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Independent reference: rank from nonvanishing minors of the first nc columns.
   function automatic int det3(input mat_t m, input int a, input int b, input int c);
      return m[0][a] * (m[1][b] * m[2][c] - m[1][c] * m[2][b])
           - m[0][b] * (m[1][a] * m[2][c] - m[1][c] * m[2][a])
           + m[0][c] * (m[1][a] * m[2][b] - m[1][b] * m[2][a]);
   endfunction

   function automatic int model_rank(input mat_t m, input int nc);
      for (int a = 0; a < nc; a++)
         for (int b = a + 1; b < nc; b++)
            for (int c = b + 1; c < nc; c++)
               if (det3(m, a, b, c) != 0) return 3;
      for (int r0 = 0; r0 < 3; r0++)
         for (int r1 = r0 + 1; r1 < 3; r1++)
            for (int a = 0; a < nc; a++)
               for (int b = a + 1; b < nc; b++)
                  if (m[r0][a] * m[r1][b] - m[r0][b] * m[r1][a] != 0) return 2;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < nc; c++)
            if (m[r][c] != 0) return 1;
      return 0;
   endfunction

   function automatic logic [(N+1)*W-1:0] pack_row(input mat_t m, input int i);
      logic [(N+1)*W-1:0] v;
      v = '0;
      for (int j = 0; j <= N; j++) begin
         int t;
         t = m[i][j];
         v[j*W +: W] = t[W-1:0];
      end
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         if (sb_q.size() == 0) begin
            check_value("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check_value("rank_a", int'(rank_a), e.ra);
            check_value("rank_ab", int'(rank_ab), e.rb);
            check_value("sol_class", int'(sol_class), e.cls);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_in_ready"}, int'(in_ready), 1);
      check_value({tag, "_busy"}, int'(busy), 0);
      check_value({tag, "_done"}, int'(done), 0);
      check_value({tag, "_rank_a"}, int'(rank_a), 0);
      check_value({tag, "_rank_ab"}, int'(rank_ab), 0);
      check_value({tag, "_sol_class"}, int'(sol_class), 0);
   endtask

   task automatic drive_rows(input mat_t m, input bit gaps, input bit hold);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         row_data = pack_row(m, i);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         if (i == N-1 && hold) begin
            in_valid = 1'b1;
            row_data = (N+1)*W'($urandom);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic wait_done(input string tag);
      bit busy_ok  = 1'b1;
      bit ready_ok = 1'b1;
      bit seen     = 1'b0;
      int lat      = 0;
      for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
         @(negedge clk);
         if (!busy)    busy_ok  = 1'b0;
         if (in_ready) ready_ok = 1'b0;
         if (done) begin
            seen     = 1'b1;
            lat      = cyc;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check_value({tag, "_done_seen"}, int'(seen), 1);
      if (!seen) begin
         sb_q.delete();
         return;
      end
      check_value({tag, "_latency_ok"}, (lat <= 2*N*(N+1)+2) ? 1 : 0, 1);
      check_value({tag, "_busy_held"}, int'(busy_ok), 1);
      check_value({tag, "_ready_low"}, int'(ready_ok), 1);
      @(negedge clk);
      check_value({tag, "_done_pulse"}, int'(done), 0);
      check_value({tag, "_busy_fall"}, int'(busy), 0);
      check_value({tag, "_ready_back"}, int'(in_ready), 1);
   endtask

   task automatic run_case(input mat_t m, input bit gaps, input bit hold,
                           input int ea, input int eb, input int ec, input string tag);
      sb_q.push_back('{ra: ea, rb: eb, cls: ec});
      drive_rows(m, gaps, hold);
      wait_done(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      mat_t c1, c2, c3, c4, c5, c6, m;
      int   ra, rb;
      c1 = '{'{3, 0, 3, 0}, '{0, 3, 3, 0}, '{3, 3, 0, 1}};
      c2 = '{'{3, 0, 3, 0}, '{0, 3, 3, 0}, '{0, 0, 0, 1}};
      c3 = '{'{3, 0, 3, 0}, '{0, 3, 3, 0}, '{0, 0, 0, 0}};
      c4 = '{'{0, 1, 0, 2}, '{1, 0, 0, 3}, '{0, 0, 1, 4}};
      c5 = '{'{-8, -8, -8, -8}, '{-8, -8, -8, -8}, '{-8, -8, -8, -8}};
      c6 = '{'{7, -8, 7, -8}, '{-8, 7, -8, 7}, '{7, 7, -8, 7}};

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_case(c1, 1'b0, 1'b0, 3, 3, 1, "unique");
      run_case(c2, 1'b0, 1'b0, 2, 3, 3, "inconsistent");
      run_case(c3, 1'b0, 1'b0, 2, 2, 2, "infinite");
      repeat (20) @(negedge clk);
      check_value("hold_rank_a", int'(rank_a), 2);
      check_value("hold_rank_ab", int'(rank_ab), 2);
      check_value("hold_sol_class", int'(sol_class), 2);
      run_case(c4, 1'b0, 1'b0, 3, 3, 1, "pivot_swap");
      run_case(c5, 1'b0, 1'b0, 1, 1, 2, "all_neg8");
      ra = model_rank(c6, 3);
      rb = model_rank(c6, 4);
      run_case(c6, 1'b0, 1'b0, ra, rb, (ra < rb) ? 3 : ((ra == 3) ? 1 : 2), "extreme");
      run_case(c1, 1'b1, 1'b1, 3, 3, 1, "gaps_hold");

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
               m[i][j] = (t % 3 == 2) ? int'($urandom_range(0, 2)) - 1
                                      : int'($urandom_range(0, 15)) - 8;
         if (t % 3 == 1)
            for (int j = 0; j < 3; j++) m[2][j] = m[0][j];
         ra = model_rank(m, 3);
         rb = model_rank(m, 4);
         run_case(m, t[0], 1'b0, ra, rb, (ra < rb) ? 3 : ((ra == 3) ? 1 : 2), "random");
      end

      run_case(c1, 1'b0, 1'b0, 3, 3, 1, "pre_reset");
      drive_rows(c1, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_elim");
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_case(c1, 1'b0, 1'b0, 3, 3, 1, "after_reset_elim");

      m = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
      for (int i = 0; i < 2; i++) begin
         row_data = pack_row(m, i);
         in_valid = 1'b1;
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check_value("reset_load_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_case(c1, 1'b0, 1'b0, 3, 3, 1, "after_reset_load");

      repeat (5) @(negedge clk);
      check_value("scoreboard_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
